// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-network event path.
// Holds the AER event record, address sizing and drop-counter width.
package snn_pkg;

  localparam int DROP_W = 16;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int AER_ADDR_W = addr_w(16);
  localparam int AER_TS_W   = 8;

  typedef struct packed {
    logic [AER_ADDR_W-1:0] addr;
    logic [AER_TS_W-1:0]   ts;
  } aer_event_t;

endpackage

// File: rtl/aer_fifo.sv
// Synchronous event FIFO with registered full/empty flags.
// Head is read straight from storage so it is stable until popped.
module aer_fifo
  import snn_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = aer_event_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     push_data_i,
  input  logic pop_i,
  output T     head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PW = $clog2(DEPTH);

  T             r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_cnt;
  logic          r_full;
  logic          r_empty;

  logic        w_push;
  logic        w_pop;
  logic [PW:0] w_cnt_nxt;

  assign w_push  = push_i & ~r_full;
  assign w_pop   = pop_i & ~r_empty;
  assign w_cnt_nxt = r_cnt
                   + {{PW{1'b0}}, w_push}
                   - {{PW{1'b0}}, w_pop};

  assign head_o  = r_mem[r_rptr];
  assign full_o  = r_full;
  assign empty_o = r_empty;

  // Storage, pointers and occupancy flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= push_data_i;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == (PW+1)'(DEPTH));
      r_empty <= (w_cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/aer_encoder.sv
// Address-event encoder: latches spikes, arbitrates round-robin,
// tags each event with its timestep and queues it for the consumer.
module aer_encoder
  import snn_pkg::*;
#(
  parameter int N_NEURONS  = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_W       = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [N_NEURONS-1:0]         spike_i,
  input  logic                         step_i,
  output logic                         aer_valid_o,
  input  logic                         aer_ready_i,
  output logic [$clog2(N_NEURONS)-1:0] aer_addr_o,
  output logic [TS_W-1:0]              aer_ts_o,
  output logic [DROP_W-1:0]            drop_cnt_o,
  output logic                         fifo_full_o
);

  localparam int AW = addr_w(N_NEURONS);

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [TS_W-1:0] ts;
  } evt_t;

  logic [N_NEURONS-1:0] r_pend;
  logic [TS_W-1:0]      r_tag [N_NEURONS];
  logic [AW-1:0]        r_ptr;
  logic [TS_W-1:0]      r_ts;
  logic [DROP_W-1:0]    r_drop;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_gnt;
  logic [AW-1:0]        w_gidx;
  logic [N_NEURONS-1:0] w_gvec;
  logic [31:0]          w_dsum;
  logic [DROP_W-1:0]    w_drop_nxt;
  evt_t                 w_push_evt;
  evt_t                 w_head;

  // Round-robin pick of the first pending bit at or after r_ptr.
  always_comb begin
    int j;
    j      = 0;
    w_gnt  = 1'b0;
    w_gidx = '0;
    w_gvec = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      j = int'(r_ptr) + i;
      if (j >= N_NEURONS) j = j - N_NEURONS;
      if (!w_gnt && !w_full && r_pend[j]) begin
        w_gnt     = 1'b1;
        w_gidx    = AW'(j);
        w_gvec[j] = 1'b1;
      end
    end
  end

  // Count spikes that collide with an ungranted pending bit.
  always_comb begin
    w_dsum = 32'(r_drop);
    for (int n = 0; n < N_NEURONS; n++) begin
      if (spike_i[n] && r_pend[n] && !w_gvec[n]) w_dsum = w_dsum + 32'd1;
    end
    w_drop_nxt = (w_dsum > 32'hFFFF) ? {DROP_W{1'b1}} : w_dsum[DROP_W-1:0];
  end

  assign w_push_evt.addr = w_gidx;
  assign w_push_evt.ts   = r_tag[w_gidx];

  // Pending bits, timestamps, arbiter pointer, timestep, drop counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend <= '0;
      for (int n = 0; n < N_NEURONS; n++) r_tag[n] <= '0;
      r_ptr  <= '0;
      r_ts   <= '0;
      r_drop <= '0;
    end else begin
      for (int n = 0; n < N_NEURONS; n++) begin
        r_pend[n] <= (r_pend[n] & ~w_gvec[n]) | spike_i[n];
        if (spike_i[n] && (!r_pend[n] || w_gvec[n])) r_tag[n] <= r_ts;
      end
      if (w_gnt) begin
        r_ptr <= (int'(w_gidx) == N_NEURONS-1) ? '0 : w_gidx + AW'(1);
      end
      if (step_i) r_ts <= r_ts + TS_W'(1);
      r_drop <= w_drop_nxt;
    end
  end

  aer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (evt_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (w_gnt),
    .push_data_i (w_push_evt),
    .pop_i       (aer_ready_i),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty)
  );

  assign aer_valid_o = ~w_empty;
  assign fifo_full_o = w_full;
  assign drop_cnt_o  = r_drop;
  assign aer_addr_o  = w_head.addr;
  assign aer_ts_o    = w_head.ts;

endmodule

// File: tb/tb_aer_encoder.sv
// Scoreboard bench for aer_encoder: directed spikes in, expected
// events queued, monitor pops and compares on every handshake.
module tb_aer_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] spike;
  logic        step;
  logic        valid;
  logic        ready;
  logic [3:0]  addr;
  logic [7:0]  ts;
  logic [15:0] drop;
  logic        full;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int a;
    int t;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  aer_encoder #(
    .N_NEURONS  (16),
    .FIFO_DEPTH (8),
    .TS_W       (8)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .spike_i     (spike),
    .step_i      (step),
    .aer_valid_o (valid),
    .aer_ready_i (ready),
    .aer_addr_o  (addr),
    .aer_ts_o    (ts),
    .drop_cnt_o  (drop),
    .fifo_full_o (full)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int a, input int t);
    exp_t e;
    e.a = a;
    e.t = t;
    q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain();
    for (int c = 0; c < 300 && q.size() != 0; c++) tick();
    chk("drain_left", q.size(), 0);
    repeat (3) tick();
  endtask

  // Monitor: every accepted event must match the queue head.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got addr=%0d ts=%0d expected none",
                 addr, ts);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ev_addr", int'(addr), e.a);
        chk("ev_ts", int'(ts), e.t);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    spike = '0;
    step  = 1'b0;
    ready = 1'b0;
    #12;
    chk("rst_valid", valid, 0);
    chk("rst_full", full, 0);
    chk("rst_drop", drop, 0);
    chk("rst_addr", addr, 0);
    chk("rst_ts", ts, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single spike, two-cycle latency.
    ready = 1'b1;
    expect_ev(2, 0);
    spike = 16'h0004;
    tick();
    spike = '0;
    @(negedge clk);
    chk("lat_k", valid, 0);
    @(negedge clk);
    chk("lat_k1", valid, 1);
    drain();

    // Round-robin over all neurons.
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 16; i++) expect_ev(i, 0);
    spike = 16'hFFFF;
    tick();
    spike = '0;
    drain();

    // Backpressure: FIFO fills, two stay pending.
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 10; i++) expect_ev(i, 0);
    spike = 16'h03FF;
    tick();
    spike = '0;
    repeat (12) tick();
    @(negedge clk);
    chk("bp_full", full, 1);
    chk("bp_valid", valid, 1);
    tick();
    ready = 1'b1;
    drain();
    chk("bp_drop", drop, 0);
    chk("bp_full_after", full, 0);

    // Drops on a held pending bit while full.
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 10; i++) expect_ev(i, 0);
    spike = 16'h03FF;
    tick();
    spike = '0;
    repeat (12) tick();
    spike = 16'h0100;
    repeat (3) tick();
    spike = '0;
    tick();
    chk("drop_cnt", drop, 3);
    ready = 1'b1;
    drain();
    chk("drop_cnt_after", drop, 3);

    // Timestep wrap.
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
    end
    expect_ev(1, 255);
    spike = 16'h0002;
    tick();
    spike = '0;
    drain();
    step = 1'b1;
    tick();
    step = 1'b0;
    expect_ev(1, 0);
    spike = 16'h0002;
    tick();
    spike = '0;
    drain();

    // Reset with events in flight.
    ready = 1'b0;
    spike = 16'h001F;
    tick();
    spike = '0;
    repeat (8) tick();
    chk("mid_valid_before", valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", valid, 0);
    chk("mid_full", full, 0);
    chk("mid_addr", addr, 0);
    chk("mid_ts", ts, 0);
    tick();
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (20) tick();
    chk("mid_valid_after", valid, 0);
    chk("mid_drop", drop, 0);
    chk("queue_left", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aer_encoder.md
AER_ENCODER -- requirements
Module: aer_encoder

Interface
REQ-001 SHALL have parameter N_NEURONS, default 16, number of neuron spike inputs.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries (power of two, ≥2).
REQ-003 SHALL have parameter TS_W, default 8, timestep counter width.
REQ-004 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port spike_i  input  N_NEURONS  per-neuron spike level, sampled every cycle.
REQ-007 SHALL have port step_i  input  1  timestep strobe, one-cycle pulse.
REQ-008 SHALL have port aer_valid_o  output  1  event available at FIFO head.
REQ-009 SHALL have port aer_ready_i  input  1  consumer accepts event.
REQ-010 SHALL have port aer_addr_o  output  $clog2(N_NEURONS)  spiking neuron index.
REQ-011 SHALL have port aer_ts_o  output  TS_W  timestep in which spike was sampled.
REQ-012 SHALL have port drop_cnt_o  output  16  saturating count of lost spikes.
REQ-013 SHALL have port fifo_full_o  output  1  event FIFO full.

Function
REQ-014 SHALL OR spike_i into a pending register each cycle, tagging each set bit with the current timestep value.
REQ-015 SHALL increment drop_cnt_o when spike_i[n] is high while pending[n] is set and not granted in that cycle; saturate at 16'hFFFF.
REQ-016 SHALL keep pending[n] set, with no drop, when spike_i[n] is high in the cycle pending[n] is granted; the new event takes the current timestep.
REQ-017 SHALL grant one pending bit per cycle via round-robin, search starting at last granted index + 1, wrapping from N_NEURONS-1 to 0.
REQ-018 SHALL grant only when the FIFO is not full at cycle start; no same-cycle pop-to-push bypass.
REQ-019 SHALL on grant push {index, tagged timestep} into the FIFO and clear that pending bit.
REQ-020 SHALL hold pending bits and round-robin pointer unchanged while the FIFO is full.
REQ-021 SHALL increment the timestep counter by one on step_i, wrapping 2^TS_W-1 to 0; spikes sampled in the step_i cycle take the pre-increment value.
REQ-022 SHALL give 2-cycle minimum latency: spike_i high before edge k gives aer_valid_o high after edge k+1 with an empty FIFO.
REQ-023 SHALL present FIFO head on aer_addr_o/aer_ts_o whenever aer_valid_o is high, stable until the aer_valid_o & aer_ready_i handshake.
REQ-024 SHALL pop exactly one entry per cycle with aer_valid_o & aer_ready_i; aer_ready_i while empty has no effect.
REQ-025 SHALL allow simultaneous push and pop when neither full nor empty, occupancy unchanged.
REQ-026 SHALL deliver events in FIFO order, never duplicated or reordered.

Reset
REQ-027 SHALL on rst_ni low asynchronously clear pending, timestamps, FIFO pointers, round-robin pointer (next search from 0), timestep counter, and drop_cnt_o.
REQ-028 SHALL drive aer_valid_o=0, fifo_full_o=0, drop_cnt_o=0, aer_addr_o=0, aer_ts_o=0 during reset.
REQ-029 SHALL on reset mid-operation discard all in-flight events; spike_i is not sampled while rst_ni is low.

Structure
REQ-030 SHALL place aer_event_t (addr, ts), address-width function, and drop-counter width constant in shared package snn_pkg.
REQ-031 SHALL implement the event FIFO as sub-module aer_fifo (synchronous, async active-low reset, full/empty flags).
REQ-032 SHALL register all outputs except aer_addr_o/aer_ts_o, which come directly from FIFO storage.

Verification
REQ-033 SHALL test single spike: spike_i=16'h0004 for 1 cycle at ts 0, ready=1 -> one event addr=2 ts=0, valid 2 cycles after sampling.
REQ-034 SHALL test round-robin: spike_i=16'hFFFF for 1 cycle -> 16 events, addr 0..15 in order, one per cycle.
REQ-035 SHALL test backpressure: ready=0, spike_i=16'h03FF for 1 cycle -> fifo_full_o after 8 pushes, addrs 8,9 held pending; ready=1 -> 10 events, drop_cnt_o=0.
REQ-036 SHALL test drop: ready=0, FIFO full, spike_i[8] high 3 extra cycles while pending -> drop_cnt_o=3.
REQ-037 SHALL test timestep wrap: 255 step_i pulses then spike_i[1] -> ts=255; one more step_i then spike_i[1] -> ts=0.
REQ-038 SHALL test reset mid-stream: assert rst_ni low with 5 events queued -> aer_valid_o=0 immediately; no stale events after release.
